// File: rtl/mux_arb_pkg.sv
// Shared parameters and types for the round-robin mux-select arbiter.
// The top and its rr_pick sub-module both import this package.
package mux_arb_pkg;

  localparam int N_DEF        = 16;
  localparam int SELW_DEF     = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Width of a counter that can hold the values 0 .. max_hold-1 with headroom.
  function automatic int hold_width(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

  localparam int HOLD_W = $clog2(MAX_HOLD_DEF) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority find-first: returns the first set request at or after i_ptr,
// wrapping from N-1 back to 0.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SELW = SELW_DEF
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);

  logic [SELW-1:0] w_pos;

  // Scan from the farthest offset down to offset 0 so the nearest hit is written last.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = i_ptr + SELW'(k);
      if (i_req[w_pos]) begin
        o_idx = w_pos;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 mux; one grant at a time,
// released on done, on request drop, or after MAX_HOLD cycles.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SELW     = SELW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [SELW-1:0] sel,
  output logic [N-1:0]    grant,
  output logic            valid,
  output logic            timeout
);

  localparam int                HOLD_W_L  = hold_width(MAX_HOLD);
  localparam logic [HOLD_W_L-1:0] HOLD_LAST = HOLD_W_L'(MAX_HOLD - 1);

  state_e                r_state, w_state_nxt;
  logic [SELW-1:0]       r_sel, w_sel_nxt;
  logic [N-1:0]          r_grant, w_grant_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic [SELW-1:0]       r_ptr, w_ptr_nxt;
  logic [HOLD_W_L-1:0]   r_hold, w_hold_nxt;

  logic [SELW-1:0]       w_idx;
  logic                  w_any;
  logic                  w_rel_normal;
  logic                  w_expire;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  assign w_rel_normal = done | ~req[r_sel];
  assign w_expire     = (r_hold == HOLD_LAST);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_grant_nxt   = r_grant;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_sel_nxt          = w_idx;
          w_grant_nxt        = '0;
          w_grant_nxt[w_idx] = 1'b1;
          w_valid_nxt        = 1'b1;
          w_hold_nxt         = '0;
          w_state_nxt        = GRANT;
        end
      end
      GRANT: begin
        if (w_rel_normal || w_expire) begin
          w_grant_nxt   = '0;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = r_sel + 1'b1;
          w_timeout_nxt = w_expire & ~w_rel_normal;
          w_state_nxt   = IDLE;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign sel     = r_sel;
  assign grant   = r_grant;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule
